instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the control decode path: accepts decoded instruction fields on a valid/ready stream, packs each into a 32-bit MIPS R/I/J instruction word, and writes the words to consecutive instruction-memory addresses. It is the boot/program loader that fills imem before the core runs, and the bench's stimulus generator for decoder checks. It holds a registered write stage, an address counter, a sticky error flag and a 3-state FSM.

Parameters:
ADDR_W, 6, word-address width; capacity is 2^ADDR_W words.
BASE_ADDR, 0, first word address written after start. Must be less than 2^ADDR_W.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse: clear counter and error, enter RUN
finish  input  1  one-cycle pulse: end the load early, enter DONE
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept this cycle
kind  input  2  0=R, 1=I, 2=J, 3=reserved
op  input  6  opcode
funct  input  6  R funct
rs  input  5  R/I rs
rt  input  5  R/I rt
rd  input  5  R rd
shamt  input  5  R shamt
imm  input  16  I immediate
target  input  26  J target
we  output  1  imem write strobe
waddr  output  ADDR_W  imem word address
wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written since start
done  output  1  high in DONE
err  output  1  sticky: a reserved kind was presented

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, we=0, waddr=0, wdata=0, count=0, done=0, err=0. Reset mid-load abandons the load. No write completes on the reset edge.
- States: IDLE -> RUN on start. RUN -> DONE on finish, or on the accept that makes count reach 2^ADDR_W-BASE_ADDR. DONE -> RUN on start. Reset from any state -> IDLE.
- in_ready = (state==RUN) & ~start & ~finish. This is combinational from state and pulses, with no dependence on in_valid.
- Accept = in_valid & in_ready. Latency is 1 cycle: on the edge after an accept with kind!=3, we=1, waddr=BASE_ADDR+count (pre-increment value), wdata=encoded word, and count increments. we is 0 on every other cycle. Back-to-back accepts give one write per cycle.
- Encoding:
  - R: {op, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm}.
  - J: {op, target}.
  - Unused fields for the selected kind are ignored.
  - op is passed unchanged. The encoder does not force op=0 for R.
- kind==3 accepted: no write, count unchanged, err set. err stays 1 until reset or start. The handshake still completes, so the item is consumed.
- start in any state: count=0, err=0, state=RUN, and no accept that cycle. start in RUN restarts the load at BASE_ADDR.
- start and finish in the same cycle: start wins.
- finish in IDLE or DONE: ignored.
- Full: the final accept's write occurs on the same edge that enters DONE. in_ready is 0 from then on. in_valid in DONE is ignored and never overwrites imem.
- waddr and wdata hold their last values when we=0.
- count saturates at 2^ADDR_W-BASE_ADDR. It never wraps.

Test Plan:
- R-type: start, then kind=0 op=0 rs=17 rt=18 rd=16 shamt=0 funct=0x20 -> next cycle we=1 waddr=0 wdata=0x02328020, count=1.
- Back-to-back I then J: kind=1 op=8 rs=0 rt=8 imm=5, then kind=2 op=2 target=0x10 -> consecutive writes 0x20080005@0 and 0x08000010@1, we high two cycles, count=2.
- Full with ADDR_W=2, BASE_ADDR=0: in_valid held high with 5 items -> exactly 4 writes at 0..3, done=1 and in_ready=0 after the 4th, 5th item never written, count=4.
- Reserved/err: kind=3 between two valid items -> writes at 0 and 1 only, err=1 and stays 1. Next start -> err=0, count=0.
- finish and start/finish collision: finish after 2 writes -> done=1, count=2. start and finish together -> state RUN, in_ready=0 that cycle, 1 next cycle.
- Reset mid-run: reset low for one edge during a stream of valids -> outputs return to reset values, no further we. After release, in_ready=0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Program loader for the instruction memory. Decoded instruction fields come
// in on a valid/ready stream, are packed into 32-bit MIPS R/I/J words and
// written to consecutive imem word addresses starting at BASE_ADDR. The load
// is opened by a start pulse and closed either by a finish pulse or by
// filling the remaining address space.
//
// Parameters:
//   ADDR_W     word-address width, capacity is 2^ADDR_W words
//   BASE_ADDR  first word address written after start (< 2^ADDR_W)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      one-cycle pulse: clear counter and error, enter RUN
//   finish     one-cycle pulse: end the load early, enter DONE
//   in_valid   field bundle valid
//   in_ready   encoder can accept this cycle
//   kind       0=R, 1=I, 2=J, 3=reserved
//   op, funct, rs, rt, rd, shamt, imm, target   instruction fields
//   we         imem write strobe
//   waddr      imem word address
//   wdata      encoded instruction word
//   count      words written since start
//   done       high while in DONE
//   err        sticky: a reserved kind was consumed
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        kind,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    // Number of words that fit between BASE_ADDR and the top of memory.
    localparam int              CAP_INT = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W:0] CAP     = CAP_INT[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                accept;
    logic                writeOk;
    logic [ADDR_W:0]     countInc;
    logic [31:0]         encoded;

    // Ready only depends on state and the control pulses, never on in_valid,
    // so a pulse cycle can never swallow an item.
    assign in_ready = (state_q == RUN) & ~start & ~finish;
    assign accept   = in_valid & in_ready;
    assign writeOk  = accept & (kind != 2'd3);
    assign countInc = count_q + ONE;

    // Field packing. op is passed through as given for every kind, so R words
    // with a nonzero opcode (e.g. SPECIAL2) can still be produced.
    always_comb begin
        encoded = 32'h0;
        case (kind)
            2'd0:    encoded = {op, rs, rt, rd, shamt, funct};
            2'd1:    encoded = {op, rs, rt, imm};
            2'd2:    encoded = {op, target};
            default: encoded = 32'h0;
        endcase
    end

    // Next-state logic. start overrides everything, including a coincident
    // finish. Within RUN, the accept that fills the last free word moves to
    // DONE on the same edge that performs its write, so count never passes
    // CAP and the address can never wrap.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (start) begin
            state_d = RUN;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (finish) begin
                        state_d = DONE;
                    end else if (writeOk) begin
                        we_d    = 1'b1;
                        waddr_d = BASE + count_q[ADDR_W-1:0];
                        wdata_d = encoded;
                        count_d = countInc;
                        if (countInc == CAP) begin
                            state_d = DONE;
                        end
                    end else if (accept) begin
                        // Reserved kind: consumed, flagged, not written.
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers. Reset wins over any accept on the same
    // edge, which is how a reset mid-load abandons the item in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = count_q;
    assign done  = (state_q == DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder with a 4-word memory (ADDR_W=2,
// BASE_ADDR=0). The stimulus process pushes the hand-computed write it
// expects for every item onto a queue; the monitor pops and compares on each
// cycle where the DUT raises we, and flags any write nobody asked for.
// Counter, flag and handshake values are compared directly by the stimulus
// process.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic [1:0]        kind = 2'd0;
    logic [5:0]        op = 6'd0;
    logic [5:0]        funct = 6'd0;
    logic [4:0]        rs = 5'd0;
    logic [4:0]        rt = 5'd0;
    logic [4:0]        rd = 5'd0;
    logic [4:0]        shamt = 5'd0;
    logic [15:0]       imm = 16'd0;
    logic [25:0]       target = 26'd0;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;

    wr_t expQ[$];
    wr_t monExp;
    int  checks = 0;
    int  errors = 0;

    instr_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .finish  (finish),
        .in_valid(inValid),
        .in_ready(inReady),
        .kind    (kind),
        .op      (op),
        .funct   (funct),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .count   (count),
        .done    (done),
        .err     (err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drives one field bundle; the caller decides how long it stays up.
    task automatic applyStimulus(input logic v, input logic [1:0] k,
                                 input logic [5:0] o, input logic [4:0] s,
                                 input logic [4:0] t, input logic [4:0] d,
                                 input logic [4:0] sh, input logic [5:0] f,
                                 input logic [15:0] im, input logic [25:0] tg);
        inValid = v;
        kind    = k;
        op      = o;
        rs      = s;
        rt      = t;
        rd      = d;
        shamt   = sh;
        funct   = f;
        imm     = im;
        target  = tg;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    endtask

    task automatic pushExp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        expQ.push_back('{addr: a, data: d});
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the edge
    // where the DUT updates.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite actual addr=0x%0h data=0x%0h required=no write",
                         waddr, wdata);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("waddr", 32'(waddr), 32'(monExp.addr));
                checkOutput("wdata", wdata, monExp.data);
            end
        end
    end

    initial begin
        $display("[TB] instr_encoder bench start");

        // Reset values.
        idle();
        tick();
        tick();
        checkOutput("rstWe",      32'(we),      32'd0);
        checkOutput("rstWaddr",   32'(waddr),   32'd0);
        checkOutput("rstWdata",   wdata,        32'd0);
        checkOutput("rstCount",   32'(count),   32'd0);
        checkOutput("rstDone",    32'(done),    32'd0);
        checkOutput("rstErr",     32'(err),     32'd0);
        checkOutput("rstInReady", 32'(inReady), 32'd0);

        // finish in IDLE is ignored.
        reset  = 1'b1;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        #1;
        checkOutput("idleFinishDone", 32'(done),    32'd0);
        checkOutput("idleInReady",    32'(inReady), 32'd0);

        // R-type, unused imm/target driven with junk.
        start = 1'b1;
        #1;
        checkOutput("startInReady", 32'(inReady), 32'd0);
        tick();
        start = 1'b0;
        #1;
        checkOutput("runInReady", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 2'd0, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF);
        pushExp(2'd0, 32'h02328020);
        tick();
        idle();
        checkOutput("rCount", 32'(count), 32'd1);
        checkOutput("rWe",    32'(we),    32'd1);
        tick();
        checkOutput("weLowAfter", 32'(we), 32'd0);

        // Restart in RUN, then back-to-back I and J.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restartCount", 32'(count), 32'd0);
        applyStimulus(1'b1, 2'd1, 6'd8, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0005, 26'h1555555);
        pushExp(2'd0, 32'h20080005);
        tick();
        applyStimulus(1'b1, 2'd2, 6'd2, 5'd31, 5'd31, 5'd7, 5'd9, 6'h15, 16'hFFFF, 26'h0000010);
        pushExp(2'd1, 32'h08000010);
        tick();
        idle();
        checkOutput("ijWeSecond", 32'(we),    32'd1);
        checkOutput("ijCount",    32'(count), 32'd2);

        // finish after two writes.
        finish = 1'b1;
        #1;
        checkOutput("finishInReady", 32'(inReady), 32'd0);
        tick();
        finish = 1'b0;
        checkOutput("finishDone",  32'(done),  32'd1);
        checkOutput("finishCount", 32'(count), 32'd2);

        // Valid items in DONE must not write.
        applyStimulus(1'b1, 2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000077);
        #1;
        checkOutput("doneInReady", 32'(inReady), 32'd0);
        tick();
        tick();
        idle();
        checkOutput("doneCountHeld", 32'(count), 32'd2);

        // Fill all four words with in_valid held; the fifth item is refused.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) begin
                applyStimulus(1'b1, 2'd0, 6'h1F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h2A, 16'hBEEF, 26'h2AAAAAA);
                pushExp(2'd3, 32'h7C22192A);
            end else begin
                applyStimulus(1'b1, 2'd2, 6'd3, 5'd5, 5'd6, 5'd7, 5'd8, 6'h11, 16'h1234, 26'(k));
                if (k <= 4) begin
                    pushExp(2'(k - 1), 32'h0C000000 | 32'(k));
                end
            end
            tick();
            if (k == 3) begin
                checkOutput("preFullDone", 32'(done), 32'd0);
            end
            if (k == 4) begin
                applyStimulus(1'b1, 2'd2, 6'd3, 5'd5, 5'd6, 5'd7, 5'd8, 6'h11, 16'h1234, 26'd5);
                #1;
                checkOutput("fullDone",    32'(done),    32'd1);
                checkOutput("fullInReady", 32'(inReady), 32'd0);
            end
        end
        idle();
        checkOutput("fullCount", 32'(count), 32'd4);
        checkOutput("fullWeLow", 32'(we),    32'd0);

        // Reserved kind between two valid items.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("startCountClear", 32'(count), 32'd0);
        checkOutput("startLeavesDone", 32'(done),  32'd0);
        applyStimulus(1'b1, 2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000021);
        pushExp(2'd0, 32'h0C000021);
        tick();
        applyStimulus(1'b1, 2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
        tick();
        applyStimulus(1'b1, 2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000022);
        pushExp(2'd1, 32'h0C000022);
        tick();
        idle();
        tick();
        checkOutput("errSet",    32'(err),   32'd1);
        checkOutput("errCount",  32'(count), 32'd2);
        tick();
        checkOutput("errSticky", 32'(err),   32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("errCleared",      32'(err),   32'd0);
        checkOutput("errCountCleared", 32'(count), 32'd0);

        // start and finish together: start wins.
        start  = 1'b1;
        finish = 1'b1;
        #1;
        checkOutput("collideInReady", 32'(inReady), 32'd0);
        tick();
        start  = 1'b0;
        finish = 1'b0;
        #1;
        checkOutput("collideRunReady", 32'(inReady), 32'd1);
        checkOutput("collideDone",     32'(done),    32'd0);

        // Reset mid-stream.
        applyStimulus(1'b1, 2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000031);
        pushExp(2'd0, 32'h0C000031);
        tick();
        applyStimulus(1'b1, 2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000032);
        pushExp(2'd1, 32'h0C000032);
        tick();
        applyStimulus(1'b1, 2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000033);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("midRstWe",    32'(we),    32'd0);
        checkOutput("midRstWaddr", 32'(waddr), 32'd0);
        checkOutput("midRstWdata", wdata,      32'd0);
        checkOutput("midRstCount", 32'(count), 32'd0);
        checkOutput("midRstDone",  32'(done),  32'd0);
        tick();
        tick();
        #1;
        checkOutput("postRstInReady", 32'(inReady), 32'd0);
        checkOutput("postRstCount",   32'(count),   32'd0);
        idle();
        tick();
        tick();
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
